// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin data-memory arbiter with locked bursts and range checking
module dmem_arbiter #(
  parameter int DEPTH    = 4096,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_lock,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_lock,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rv0_q, rv1_q, err0_q, err1_q;
  logic [31:0]   rd0_q, rd1_q;
  logic          in0, in1, any_gnt, lock_g;
  assign in0 = r0_addr < 32'(DEPTH);
  assign in1 = r1_addr < 32'(DEPTH);
  // A lock owner is served exclusively; otherwise a lone requester wins, and ptr breaks ties.
  assign r0_gnt = !rst && r0_req && (state_q == LOCK0 || (state_q == IDLE && (!r1_req || !ptr_q)));
  assign r1_gnt = !rst && r1_req && (state_q == LOCK1 || (state_q == IDLE && (!r0_req || ptr_q)));
  assign any_gnt = r0_gnt || r1_gnt;
  assign lock_g = r0_gnt ? r0_lock : r1_lock;
  assign mem_a  = r0_gnt ? r0_addr : r1_gnt ? r1_addr : '0;
  assign mem_wd = r0_gnt ? r0_wdata : r1_gnt ? r1_wdata : '0;
  assign mem_we = (r0_gnt && r0_we && in0) || (r1_gnt && r1_we && in1);
  // Responses are masked while reset is high so a beat granted just before reset reports nothing.
  assign r0_rvalid = rv0_q && !rst;
  assign r1_rvalid = rv1_q && !rst;
  assign r0_err    = err0_q && !rst;
  assign r1_err    = err1_q && !rst;
  assign r0_rdata  = rd0_q;
  assign r1_rdata  = rd1_q;
  // Next arbitration state: enter a lock on a locked IDLE grant, leave it on idle, unlock or hold cap.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (state_q == IDLE) begin
      if (any_gnt) begin
        ptr_d = r0_gnt;
        if (lock_g && MAX_HOLD > 1) begin
          state_d = r1_gnt ? LOCK1 : LOCK0;
          hold_d  = HW'(1);
        end
      end
    end else if (!any_gnt) begin
      state_d = IDLE;
      ptr_d   = state_q == LOCK0;
      hold_d  = '0;
    end else begin
      hold_d = hold_q + 1'b1;
      if (!lock_g || hold_d == HW'(MAX_HOLD)) begin
        state_d = IDLE;
        ptr_d   = r0_gnt;
        hold_d  = '0;
      end
    end
  end
  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end
  // Per-requester read data, valid and error responses one cycle after the granted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      rv0_q  <= r0_gnt && !r0_we;
      rv1_q  <= r1_gnt && !r1_we;
      err0_q <= r0_gnt && !in0;
      err1_q <= r1_gnt && !in1;
      if (r0_gnt && !r0_we) rd0_q <= in0 ? mem_rd : '0;
      if (r1_gnt && !r1_we) rd1_q <= in1 ? mem_rd : '0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int DEPTH = 4096;
  localparam int MAXH  = 3;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, lock, we, gnt, rvalid, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  int          owner, held, ptr;
  logic [1:0]  e_rv, e_err;
  logic [31:0] e_rd [2];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_lock(lock[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt[0]), .r0_rvalid(rvalid[0]), .r0_rdata(rdata[0]), .r0_err(err[0]),
    .r1_req(req[1]), .r1_lock(lock[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt[1]), .r1_rvalid(rvalid[1]), .r1_rdata(rdata[1]), .r1_err(err[1]),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign mem_rd = mem_a < DEPTH ? mem[mem_a[11:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (mem_we) mem[mem_a[11:0]] <= mem_wd;

  // Who the rules say is served right now: lock owner only, else lone requester, else ptr.
  function automatic int pick();
    if (rst) return -1;
    if (owner >= 0) return req[owner] ? owner : -1;
    if (req == 2'b11) return ptr;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic tick();
    int g;
    g = pick();
    @(posedge clk);
    if (rst) begin
      owner = -1; ptr = 0; held = 0; e_rv = 0; e_err = 0; e_rd[0] = 0; e_rd[1] = 0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        e_rv[n]  = (g == n) && !we[n];
        e_err[n] = (g == n) && addr[n] >= DEPTH;
        if (g == n && !we[n]) e_rd[n] = addr[n] < DEPTH ? ref_mem[addr[n][11:0]] : 32'h0;
      end
      if (g >= 0) begin
        if (we[g] && addr[g] < DEPTH) ref_mem[addr[g][11:0]] = wdata[g];
      end
      if (owner >= 0) begin
        if (g < 0) begin
          ptr = 1 - owner; owner = -1; held = 0;
        end else begin
          held++;
          if (!lock[g] || held >= MAXH) begin owner = -1; ptr = 1 - g; held = 0; end
        end
      end else if (g >= 0) begin
        ptr = 1 - g;
        if (lock[g] && MAXH > 1) begin owner = g; held = 1; end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; lock = 0; we = 0;
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 2'b11; we = 2'b11; lock = 2'b11; addr[0] = 7; addr[1] = 9;
    #4;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    tick();
    tick();
    rst = 0; idle_inputs();
    #4;
    checks++; if (rvalid !== 2'b00 || err !== 2'b00) begin errors++; $display("FAIL reset_resp rvalid=%b err=%b want 00/00", rvalid, err); end
    checks++; if (rdata[0] !== 0 || rdata[1] !== 0) begin errors++; $display("FAIL reset_rdata got %h %h want 0 0", rdata[0], rdata[1]); end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    mem[5] = 32'hDEAD_BEEF; ref_mem[5] = 32'hDEAD_BEEF;
    req = 2'b01; addr[0] = 5;
    #4;
    checks++; if (gnt !== 2'b01 || mem_a !== 32'd5) begin errors++; $display("FAIL read_gnt gnt=%b mem_a=%0d want 01/5", gnt, mem_a); end
    tick();
    idle_inputs();
    #4;
    checks++; if (rvalid !== 2'b01 || rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_resp rvalid=%b rdata=%h want 01/deadbeef", rvalid, rdata[0]); end
    tick();
    #4;
    checks++; if (rvalid !== 2'b00 || rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_hold rvalid=%b rdata=%h want 00/deadbeef", rvalid, rdata[0]); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    req = 2'b11; addr[0] = 1; addr[1] = 2;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++; if (gnt !== (i % 2 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_%0d got %b want %b", i, gnt, i % 2 ? 2'b10 : 2'b01); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_burst_cap();
    do_reset();
    lock = 2'b10; addr[0] = 3; addr[1] = 4;
    for (int i = 0; i < 4; i++) begin
      req = i == 0 ? 2'b10 : 2'b11;
      #4;
      checks++; if (gnt !== (i < 3 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL burst_%0d got %b want %b", i, gnt, i < 3 ? 2'b10 : 2'b01); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_out_of_range();
    logic [31:0] w0;
    do_reset();
    w0 = mem[0];
    req = 2'b01; we = 2'b01; addr[0] = 4096; wdata[0] = 32'h1234_5678;
    #4;
    checks++; if (gnt !== 2'b01 || mem_we !== 1'b0) begin errors++; $display("FAIL oor_write gnt=%b mem_we=%b want 01/0", gnt, mem_we); end
    tick();
    idle_inputs();
    #4;
    checks++; if (err !== 2'b01 || rvalid !== 2'b00) begin errors++; $display("FAIL oor_write_err err=%b rvalid=%b want 01/00", err, rvalid); end
    checks++; if (mem[0] !== w0) begin errors++; $display("FAIL oor_mem_unchanged got %h want %h", mem[0], w0); end
    req = 2'b01; addr[0] = 5000;
    tick();
    idle_inputs();
    #4;
    checks++; if (rvalid !== 2'b01 || rdata[0] !== 0 || err !== 2'b01) begin errors++; $display("FAIL oor_read rvalid=%b rdata=%h err=%b want 01/0/01", rvalid, rdata[0], err); end
    tick();
    #4;
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL err_pulse got %b want 00", err); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 2'b11; lock = 2'b01; addr[0] = 10; addr[1] = 11;
    #4;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_first got %b want 01", gnt); end
    tick();
    #4;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_locked got %b want 01", gnt); end
    tick();
    rst = 1;
    #4;
    checks++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin errors++; $display("FAIL midrst_during gnt=%b rvalid=%b want 00/00", gnt, rvalid); end
    tick();
    rst = 0; req = 2'b10; lock = 0;
    #4;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL midrst_after got %b want 10", gnt); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int g;
    int bad;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 59) == 0;
      for (int n = 0; n < 2; n++) begin
        req[n]   = $urandom_range(0, 9) < 7;
        lock[n]  = $urandom_range(0, 1);
        we[n]    = $urandom_range(0, 2) == 0;
        addr[n]  = $urandom_range(0, 11) == 0 ? 32'(DEPTH + $urandom_range(0, 64)) : 32'($urandom_range(0, 63));
        wdata[n] = $urandom;
      end
      #4;
      g = pick();
      checks++; if (gnt !== (g == 0 ? 2'b01 : g == 1 ? 2'b10 : 2'b00)) begin errors++; $display("FAIL rnd_gnt cyc=%0d got %b want idx %0d", c, gnt, g); end
      checks++; if (mem_a !== (g < 0 ? 32'h0 : addr[g]) || mem_wd !== (g < 0 ? 32'h0 : wdata[g])) begin errors++; $display("FAIL rnd_mem_bus cyc=%0d a=%h wd=%h", c, mem_a, mem_wd); end
      checks++; if (mem_we !== (g >= 0 && we[g] && addr[g] < DEPTH)) begin errors++; $display("FAIL rnd_mem_we cyc=%0d got %b", c, mem_we); end
      checks++; if (rvalid !== (e_rv & {2{!rst}}) || err !== (e_err & {2{!rst}})) begin errors++; $display("FAIL rnd_resp cyc=%0d rvalid=%b err=%b want %b/%b", c, rvalid, err, e_rv & {2{!rst}}, e_err & {2{!rst}}); end
      checks++; if (rdata[0] !== e_rd[0] || rdata[1] !== e_rd[1]) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h %h want %h %h", c, rdata[0], rdata[1], e_rd[0], e_rd[1]); end
      tick();
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_mem_contents %0d words differ, want 0", bad); end
    idle_inputs();
  endtask

  initial begin
    owner = -1; ptr = 0; held = 0; e_rv = 0; e_err = 0; e_rd[0] = 0; e_rd[1] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_burst_cap();
    test_out_of_range();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
